serial_subtractor: RTL

- Bit-serial, LSB-first subtractor computing DIFF = A - B over WIDTH clock cycles under a start/done handshake.
- Serves as the inverse-direction companion to the team's per-bit registered ripple adder chain.
- Trades latency for a single full-subtractor cell plus shift registers.
- Reports the difference, the final borrow (A < B, unsigned) and a zero flag.

---
 rtl/serial_subtractor.sv | 94 +++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = A - B over WIDTH cycles using one
// full-subtractor cell, with start/done handshake, final borrow and zero flag.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: start is a request sampled only in IDLE; done is a one-cycle
  // pulse after the completing edge, with diff/borrow/zero valid from then on.
  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] r_next;

  // The single full-subtractor cell acting on the current LSBs.
  always_comb begin
    a_bit   = a_sh[0];
    b_bit   = b_sh[0];
    d_bit   = a_bit ^ b_bit ^ br;
    br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    r_next  = {d_bit, r_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      br     <= 1'b0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_next;
          br   <= br_next;
          cnt  <= cnt + 1'b1;
          // Last bit: publish the fully shifted result including this edge's d.
          if (cnt == LAST) begin
            diff   <= r_next;
            borrow <= br_next;
            zero   <= (r_next == '0);
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
